// File: rtl/axi_burst_master.sv
`default_nettype none
// ---------------------------------------------------------------------------
// axi_burst_master: writes i_len+1 stream beats as one INCR burst, then
// reads them back as one INCR burst and streams them out.  Rev 1.0
// ---------------------------------------------------------------------------
module axi_burst_master #(
  parameter int C_M_AXI_ID_WIDTH   = 1,
  parameter int C_M_AXI_ADDR_WIDTH = 6,
  parameter int C_M_AXI_DATA_WIDTH = 512
) (
  input  logic                            M_AXI_ACLK,
  input  logic                            M_AXI_ARESETN,
  input  logic                            i_start,
  input  logic [C_M_AXI_ADDR_WIDTH-1:0]   i_addr,
  input  logic [7:0]                      i_len,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   i_wr_data,
  input  logic                            i_wr_valid,
  output logic                            o_wr_ready,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   o_rd_data,
  output logic                            o_rd_valid,
  input  logic                            i_rd_ready,
  output logic                            o_busy,
  output logic                            o_done,
  output logic                            o_error,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_AWID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_AWADDR,
  output logic [7:0]                      M_AXI_AWLEN,
  output logic [2:0]                      M_AXI_AWSIZE,
  output logic [1:0]                      M_AXI_AWBURST,
  output logic                            M_AXI_AWLOCK,
  output logic [3:0]                      M_AXI_AWCACHE,
  output logic [2:0]                      M_AXI_AWPROT,
  output logic [3:0]                      M_AXI_AWQOS,
  output logic                            M_AXI_AWVALID,
  input  logic                            M_AXI_AWREADY,
  output logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_WDATA,
  output logic [C_M_AXI_DATA_WIDTH/8-1:0] M_AXI_WSTRB,
  output logic                            M_AXI_WLAST,
  output logic                            M_AXI_WVALID,
  input  logic                            M_AXI_WREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_BID,
  input  logic [1:0]                      M_AXI_BRESP,
  input  logic                            M_AXI_BVALID,
  output logic                            M_AXI_BREADY,
  output logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_ARID,
  output logic [C_M_AXI_ADDR_WIDTH-1:0]   M_AXI_ARADDR,
  output logic [7:0]                      M_AXI_ARLEN,
  output logic [2:0]                      M_AXI_ARSIZE,
  output logic [1:0]                      M_AXI_ARBURST,
  output logic                            M_AXI_ARLOCK,
  output logic [3:0]                      M_AXI_ARCACHE,
  output logic [2:0]                      M_AXI_ARPROT,
  output logic [3:0]                      M_AXI_ARQOS,
  output logic                            M_AXI_ARVALID,
  input  logic                            M_AXI_ARREADY,
  input  logic [C_M_AXI_ID_WIDTH-1:0]     M_AXI_RID,
  input  logic [C_M_AXI_DATA_WIDTH-1:0]   M_AXI_RDATA,
  input  logic [1:0]                      M_AXI_RRESP,
  input  logic                            M_AXI_RLAST,
  input  logic                            M_AXI_RVALID,
  output logic                            M_AXI_RREADY
);

  localparam logic [2:0] c_st_idle = 3'd0;
  localparam logic [2:0] c_st_aw   = 3'd1;
  localparam logic [2:0] c_st_w    = 3'd2;
  localparam logic [2:0] c_st_b    = 3'd3;
  localparam logic [2:0] c_st_ar   = 3'd4;
  localparam logic [2:0] c_st_r    = 3'd5;
  localparam logic [2:0] c_st_done = 3'd6;

  localparam logic [2:0] c_axsize  = 3'($clog2(C_M_AXI_DATA_WIDTH / 8));

  logic [2:0]                    r_state;
  logic [2:0]                    w_next_state;
  logic [C_M_AXI_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                    r_len;
  logic [7:0]                    r_cnt;
  logic                          r_error;
  logic                          w_cnt_last;
  logic                          w_w_hs;
  logic                          w_r_hs;
  logic                          w_r_err;
  logic                          w_unused;

  assign w_cnt_last = (r_cnt == r_len);
  assign w_w_hs     = (r_state == c_st_w) && i_wr_valid && M_AXI_WREADY;
  assign w_r_hs     = (r_state == c_st_r) && M_AXI_RVALID && i_rd_ready;
  // RLAST must coincide exactly with the final expected beat.
  assign w_r_err    = (M_AXI_RRESP != 2'b00) || (M_AXI_RLAST != w_cnt_last);
  assign w_unused   = ^{M_AXI_BID, M_AXI_RID};

  assign M_AXI_AWID    = '0;
  assign M_AXI_AWADDR  = r_addr;
  assign M_AXI_AWLEN   = r_len;
  assign M_AXI_AWSIZE  = c_axsize;
  assign M_AXI_AWBURST = 2'b01;
  assign M_AXI_AWLOCK  = 1'b0;
  assign M_AXI_AWCACHE = 4'd0;
  assign M_AXI_AWPROT  = 3'd0;
  assign M_AXI_AWQOS   = 4'd0;
  assign M_AXI_ARID    = '0;
  assign M_AXI_ARADDR  = r_addr;
  assign M_AXI_ARLEN   = r_len;
  assign M_AXI_ARSIZE  = c_axsize;
  assign M_AXI_ARBURST = 2'b01;
  assign M_AXI_ARLOCK  = 1'b0;
  assign M_AXI_ARCACHE = 4'd0;
  assign M_AXI_ARPROT  = 3'd0;
  assign M_AXI_ARQOS   = 4'd0;
  assign M_AXI_WDATA   = i_wr_data;
  assign M_AXI_WSTRB   = '1;
  assign o_rd_data     = M_AXI_RDATA;
  assign o_error       = r_error;

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) r_state <= c_st_idle;
    else                r_state <= w_next_state;
  end

  always_ff @(posedge M_AXI_ACLK) begin
    if (!M_AXI_ARESETN) begin
      r_addr  <= '0;
      r_len   <= 8'd0;
      r_cnt   <= 8'd0;
      r_error <= 1'b0;
    end else begin
      case (r_state)
        c_st_idle: if (i_start) begin
          r_addr  <= i_addr;
          r_len   <= i_len;
          r_cnt   <= 8'd0;
          r_error <= 1'b0;
        end
        c_st_w: if (w_w_hs) r_cnt <= w_cnt_last ? 8'd0 : r_cnt + 8'd1;
        c_st_b: if (M_AXI_BVALID && (M_AXI_BRESP != 2'b00)) r_error <= 1'b1;
        c_st_r: if (w_r_hs) begin
          r_cnt <= r_cnt + 8'd1;
          if (w_r_err) r_error <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_st_idle: if (i_start)          w_next_state = c_st_aw;
      c_st_aw:   if (M_AXI_AWREADY)    w_next_state = c_st_w;
      c_st_w:    if (w_w_hs && w_cnt_last) w_next_state = c_st_b;
      c_st_b:    if (M_AXI_BVALID)     w_next_state = c_st_ar;
      c_st_ar:   if (M_AXI_ARREADY)    w_next_state = c_st_r;
      c_st_r:    if (w_r_hs && w_cnt_last) w_next_state = c_st_done;
      c_st_done:                       w_next_state = c_st_idle;
      default:                         w_next_state = c_st_idle;
    endcase
  end

  always_comb begin
    M_AXI_AWVALID = 1'b0;
    M_AXI_WVALID  = 1'b0;
    M_AXI_WLAST   = 1'b0;
    o_wr_ready    = 1'b0;
    M_AXI_BREADY  = 1'b0;
    M_AXI_ARVALID = 1'b0;
    M_AXI_RREADY  = 1'b0;
    o_rd_valid    = 1'b0;
    o_done        = 1'b0;
    o_busy        = (r_state != c_st_idle);
    case (r_state)
      c_st_aw: M_AXI_AWVALID = 1'b1;
      c_st_w: begin
        M_AXI_WVALID = i_wr_valid;
        M_AXI_WLAST  = w_cnt_last;
        o_wr_ready   = M_AXI_WREADY;
      end
      c_st_b:  M_AXI_BREADY  = 1'b1;
      c_st_ar: M_AXI_ARVALID = 1'b1;
      c_st_r: begin
        o_rd_valid   = M_AXI_RVALID;
        M_AXI_RREADY = i_rd_ready;
      end
      c_st_done: o_done = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_axi_burst_master.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_axi_burst_master: table-driven bench with a behavioural zero-wait slave.
// ---------------------------------------------------------------------------
module tb_axi_burst_master;

  localparam int IDW = 1;
  localparam int AW  = 6;
  localparam int DW  = 512;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rstn;
  logic            i_start;
  logic [AW-1:0]   i_addr;
  logic [7:0]      i_len;
  logic [DW-1:0]   i_wr_data;
  logic            i_wr_valid, o_wr_ready;
  logic [DW-1:0]   o_rd_data;
  logic            o_rd_valid, i_rd_ready;
  logic            o_busy, o_done, o_error;
  logic [IDW-1:0]  awid, arid, bid, rid;
  logic [AW-1:0]   awaddr, araddr;
  logic [7:0]      awlen, arlen;
  logic [2:0]      awsize, arsize, awprot, arprot;
  logic [1:0]      awburst, arburst, bresp, rresp;
  logic            awlock, arlock;
  logic [3:0]      awcache, arcache, awqos, arqos;
  logic            awvalid, awready, wlast, wvalid, wready, bvalid, bready;
  logic            arvalid, arready, rlast, rvalid, rready;
  logic [DW-1:0]   wdata, rdata;
  logic [DW/8-1:0] wstrb;

  axi_burst_master #(.C_M_AXI_ID_WIDTH(IDW), .C_M_AXI_ADDR_WIDTH(AW), .C_M_AXI_DATA_WIDTH(DW)) dut (
    .M_AXI_ACLK(clk), .M_AXI_ARESETN(rstn),
    .i_start(i_start), .i_addr(i_addr), .i_len(i_len),
    .i_wr_data(i_wr_data), .i_wr_valid(i_wr_valid), .o_wr_ready(o_wr_ready),
    .o_rd_data(o_rd_data), .o_rd_valid(o_rd_valid), .i_rd_ready(i_rd_ready),
    .o_busy(o_busy), .o_done(o_done), .o_error(o_error),
    .M_AXI_AWID(awid), .M_AXI_AWADDR(awaddr), .M_AXI_AWLEN(awlen), .M_AXI_AWSIZE(awsize),
    .M_AXI_AWBURST(awburst), .M_AXI_AWLOCK(awlock), .M_AXI_AWCACHE(awcache),
    .M_AXI_AWPROT(awprot), .M_AXI_AWQOS(awqos), .M_AXI_AWVALID(awvalid), .M_AXI_AWREADY(awready),
    .M_AXI_WDATA(wdata), .M_AXI_WSTRB(wstrb), .M_AXI_WLAST(wlast), .M_AXI_WVALID(wvalid),
    .M_AXI_WREADY(wready),
    .M_AXI_BID(bid), .M_AXI_BRESP(bresp), .M_AXI_BVALID(bvalid), .M_AXI_BREADY(bready),
    .M_AXI_ARID(arid), .M_AXI_ARADDR(araddr), .M_AXI_ARLEN(arlen), .M_AXI_ARSIZE(arsize),
    .M_AXI_ARBURST(arburst), .M_AXI_ARLOCK(arlock), .M_AXI_ARCACHE(arcache),
    .M_AXI_ARPROT(arprot), .M_AXI_ARQOS(arqos), .M_AXI_ARVALID(arvalid), .M_AXI_ARREADY(arready),
    .M_AXI_RID(rid), .M_AXI_RDATA(rdata), .M_AXI_RRESP(rresp), .M_AXI_RLAST(rlast),
    .M_AXI_RVALID(rvalid), .M_AXI_RREADY(rready)
  );

  typedef struct {
    logic [7:0]    len;
    logic [AW-1:0] addr;
    logic [1:0]    bresp;
    int            rlast_beat;   // -1: RLAST on the true last beat
    bit            wr_gaps;
    bit            rd_toggle;
    bit            hold_start;
    int            exp_lat;      // 0: latency not checked
    bit            exp_err;
  } vec_t;

  vec_t vecs[7];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] stim(input int tag, input int beat);
    logic [DW-1:0] v;
    v = '0;
    v[7:0]     = beat[7:0];
    v[15:8]    = tag[7:0];
    v[511:504] = 8'hA5;
    return v;
  endfunction

  task automatic idle_inputs();
    i_start = 0; i_wr_valid = 0; i_rd_ready = 0; i_wr_data = '0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0; bid = '0;
    arready = 0; rvalid = 0; rdata = '0; rresp = 0; rlast = 0; rid = '0;
  endtask

  task automatic run_txn(input int tag, input vec_t v);
    logic [DW-1:0] mem [256];
    int  wbeat = 0, rbeat = 0, cyc = 0, done_cnt = 0, aw_cnt = 0;
    bit  b_taken = 0, ar_taken = 0, fin = 0;
    int  last = int'(v.len);
    @(posedge clk); #1;
    i_start = 1; i_addr = v.addr; i_len = v.len;
    @(posedge clk); #1;
    if (!v.hold_start) i_start = 0;
    i_addr = ~v.addr; i_len = 8'hFF;
    while (!fin && cyc < 400) begin
      awready    = 1; arready = 1; wready = 1;
      i_wr_valid = (wbeat <= last) && !(v.wr_gaps && (cyc % 3 == 1));
      i_wr_data  = stim(tag, wbeat);
      bvalid     = (wbeat == last + 1) && !b_taken;
      bresp      = v.bresp;
      rvalid     = ar_taken && (rbeat <= last);
      rdata      = mem[rbeat[7:0]];
      rlast      = (v.rlast_beat >= 0) ? (rbeat == v.rlast_beat) : (rbeat == last);
      i_rd_ready = v.rd_toggle ? (cyc % 2 == 1) : 1'b1;
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        check($sformatf("t%0d_start_aw_busy", tag), {awvalid, o_busy}, 2'b11);
        check($sformatf("t%0d_err_cleared", tag), o_error, 0);
      end
      if (awvalid && awready) begin
        aw_cnt++;
        check($sformatf("t%0d_aw", tag), {awaddr, awlen, awsize, awburst}, {v.addr, v.len, 3'd6, 2'b01});
      end
      if (wvalid && wready && wbeat <= last) begin
        check($sformatf("t%0d_wdata%0d", tag, wbeat), wdata, stim(tag, wbeat));
        check($sformatf("t%0d_wlast%0d", tag, wbeat), wlast, (wbeat == last));
        mem[wbeat[7:0]] = wdata;
        wbeat++;
      end
      if (bvalid && bready) b_taken = 1;
      if (arvalid && arready) begin
        ar_taken = 1;
        check($sformatf("t%0d_ar", tag), {araddr, arlen, arsize, arburst}, {v.addr, v.len, 3'd6, 2'b01});
      end
      if (rvalid && rready && rbeat <= last) begin
        check($sformatf("t%0d_rdata%0d", tag, rbeat), {o_rd_valid, o_rd_data}, {1'b1, stim(tag, rbeat)});
        rbeat++;
      end
      if (o_done) begin
        done_cnt++;
        fin = 1;
        check($sformatf("t%0d_err_at_done", tag), o_error, v.exp_err);
        if (v.exp_lat != 0) check($sformatf("t%0d_latency", tag), cyc, v.exp_lat);
      end
      @(posedge clk); #1;
    end
    check($sformatf("t%0d_no_timeout", tag), fin, 1);
    idle_inputs();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (o_done) done_cnt++;
      check($sformatf("t%0d_idle%0d_busy_done", tag, k), {o_busy, o_done}, 2'b00);
      check($sformatf("t%0d_idle%0d_err_sticky", tag, k), o_error, v.exp_err);
    end
    check($sformatf("t%0d_counts", tag), {32'(aw_cnt), 32'(wbeat), 32'(rbeat), 32'(done_cnt)},
          {32'd1, 32'(last + 1), 32'(last + 1), 32'd1});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{len: 8'd3, addr: 6'h00, bresp: 2'd0, rlast_beat: -1, wr_gaps: 0, rd_toggle: 0, hold_start: 0, exp_lat: 12, exp_err: 0};
    vecs[1] = '{len: 8'd0, addr: 6'h08, bresp: 2'd0, rlast_beat: -1, wr_gaps: 0, rd_toggle: 0, hold_start: 0, exp_lat: 6,  exp_err: 0};
    vecs[2] = '{len: 8'd7, addr: 6'h10, bresp: 2'd0, rlast_beat: -1, wr_gaps: 1, rd_toggle: 1, hold_start: 0, exp_lat: 0,  exp_err: 0};
    vecs[3] = '{len: 8'd3, addr: 6'h20, bresp: 2'd2, rlast_beat: -1, wr_gaps: 0, rd_toggle: 0, hold_start: 0, exp_lat: 12, exp_err: 1};
    vecs[4] = '{len: 8'd3, addr: 6'h04, bresp: 2'd0, rlast_beat: 1,  wr_gaps: 0, rd_toggle: 0, hold_start: 0, exp_lat: 12, exp_err: 1};
    vecs[5] = '{len: 8'd2, addr: 6'h3C, bresp: 2'd0, rlast_beat: -1, wr_gaps: 0, rd_toggle: 0, hold_start: 0, exp_lat: 10, exp_err: 0};
    vecs[6] = '{len: 8'd1, addr: 6'h01, bresp: 2'd0, rlast_beat: -1, wr_gaps: 0, rd_toggle: 0, hold_start: 1, exp_lat: 8,  exp_err: 0};

    idle_inputs();
    i_addr = '0; i_len = 8'd0;
    rstn = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, o_wr_ready, o_rd_valid, o_busy, o_done, o_error}, 10'd0);
    check("reset_regs", {awaddr, awlen, araddr, arlen}, '0);
    @(posedge clk); #1;
    rstn = 1;

    for (int i = 0; i < 7; i++) run_txn(i, vecs[i]);

    // Reset pulsed in the middle of the write burst.
    begin
      int wb = 0, cyc = 0;
      @(posedge clk); #1;
      i_start = 1; i_addr = 6'h18; i_len = 8'd7;
      @(posedge clk); #1;
      i_start = 0;
      while (wb < 2 && cyc < 50) begin
        awready = 1; wready = 1; i_wr_valid = 1; i_wr_data = stim(20, wb);
        @(negedge clk);
        cyc++;
        if (wvalid && wready) wb++;
        @(posedge clk); #1;
      end
      check("midw_reached_beat2", wb, 2);
      rstn = 0;
      @(posedge clk); #1;
      rstn = 1;
      @(negedge clk);
      check("midw_reset_ctrl", {awvalid, wvalid, bready, arvalid, rready, o_wr_ready, o_busy, o_done}, 8'd0);
      check("midw_reset_regs", {awaddr, awlen}, '0);
      idle_inputs();
    end

    run_txn(30, vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
